// File: rtl/regfile_mp.sv
// Parametrised multi-port register file for the decode stage: two prioritised
// write ports, NUM_RD registered read lanes with hold, optional bypass and zero register.
module regfile_mp_rdlane #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic [ADDR_W-1:0]                   addr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs,
  input  logic                                we0,
  input  logic [ADDR_W-1:0]                   wa0,
  input  logic [DATA_W-1:0]                   wd0,
  input  logic                                we1,
  input  logic [ADDR_W-1:0]                   wa1,
  input  logic [DATA_W-1:0]                   wd1,
  output logic [DATA_W-1:0]                   data
);
  logic [DATA_W-1:0] nxt;

  // Port 1 outranks port 0 on bypass, matching storage priority; r0 wins over both.
  always_comb begin
    nxt = regs[addr];
    if (BYPASS != 0) begin
      if (we1 && wa1 == addr)      nxt = wd1;
      else if (we0 && wa0 == addr) nxt = wd0;
    end
    if (ZERO_REG != 0 && addr == '0) nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  data <= '0;
    else if (en) data <= nxt;
  end
endmodule

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd1,
  output logic                       wr_conflict
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0]  regs;
  logic [NUM_RD-1:0][ADDR_W-1:0] ra;
  logic [NUM_RD-1:0][DATA_W-1:0] rd;
  logic                          wr0_ok, wr1_ok;

  assign ra      = rd_addr;
  assign rd_data = rd;
  assign wr0_ok  = we0 && !(ZERO_REG != 0 && wa0 == '0);
  assign wr1_ok  = we1 && !(ZERO_REG != 0 && wa1 == '0);

  // Port 1 is assigned last so it takes the entry on an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      if (wr0_ok) regs[wa0] <= wd0;
      if (wr1_ok) regs[wa1] <= wd1;
      wr_conflict <= wr0_ok && wr1_ok && (wa0 == wa1);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_lane
    regfile_mp_rdlane #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_lane (
      .clk(clk), .rst_n(rst_n), .en(rd_en[k]), .addr(ra[k]), .regs(regs),
      .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .data(rd[k])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two 32x32 instances (old-data and bypass read-during-write)
// driven in lockstep from a vector table, plus a 16-bit/8-entry/4-lane instance.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus for instances a (BYPASS=0) and b (BYPASS=1)
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic        we0 = 0, we1 = 0;
  logic [4:0]  wa0 = '0, wa1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [63:0] rd_a, rd_b;
  logic        conf_a, conf_b;

  // sweep instance c
  logic [3:0]  c_en = '0;
  logic [11:0] c_addr = '0;
  logic        c_we0 = 0, c_we1 = 0;
  logic [2:0]  c_wa0 = '0, c_wa1 = '0;
  logic [15:0] c_wd0 = '0, c_wd1 = '0;
  logic [63:0] rd_c;
  logic        conf_c;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1), .wr_conflict(conf_a));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1), .wr_conflict(conf_b));
  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) u_c (
    .clk(clk), .rst_n(rst_n), .rd_en(c_en), .rd_addr(c_addr), .rd_data(rd_c),
    .we0(c_we0), .wa0(c_wa0), .wd0(c_wd0), .we1(c_we1), .wa1(c_wa1), .wd1(c_wd1),
    .wr_conflict(conf_c));

  typedef struct {
    logic        we0; logic [4:0] wa0; logic [31:0] wd0;
    logic        we1; logic [4:0] wa1; logic [31:0] wd1;
    logic [1:0]  en;  logic [4:0] ra0; logic [4:0] ra1;
    logic [31:0] a0;  logic [31:0] a1; logic [31:0] b0; logic [31:0] b1;
    logic        conf;
  } vec_t;

  typedef struct {
    logic [31:0] a0; logic [31:0] a1; logic [31:0] b0; logic [31:0] b1;
    logic        conf; int row;
  } exp_t;

  vec_t tbl [15];
  exp_t sb [$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
    we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
    rd_en = v.en; rd_addr = {v.ra1, v.ra0};
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; rd_en = '0;
    c_we0 = 0; c_we1 = 0; c_en = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    vec_t v;
    //          we0 wa0    wd0            we1 wa1    wd1            en     ra0    ra1    a0            a1            b0            b1            conf
    tbl[0]  = '{1'b1,5'd7,32'h12345678, 1'b0,5'd0,32'h0,        2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
    tbl[1]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        2'b11, 5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 1'b0};
    tbl[2]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        2'b00, 5'd0,  5'd0,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 1'b0};
    tbl[3]  = '{1'b1,5'd0,32'h5,        1'b1,5'd0,32'hFFFFFFFF, 2'b01, 5'd0,  5'd7,  32'h0,        32'h12345678, 32'h0,        32'h12345678, 1'b0};
    tbl[4]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        2'b01, 5'd0,  5'd7,  32'h0,        32'h12345678, 32'h0,        32'h12345678, 1'b0};
    tbl[5]  = '{1'b0,5'd0,32'h0,        1'b1,5'd9,32'h1,        2'b00, 5'd0,  5'd0,  32'h0,        32'h12345678, 32'h0,        32'h12345678, 1'b0};
    tbl[6]  = '{1'b1,5'd9,32'hAAAA0000, 1'b1,5'd9,32'h0000BBBB, 2'b11, 5'd9,  5'd9,  32'h1,        32'h1,        32'h0000BBBB, 32'h0000BBBB, 1'b1};
    tbl[7]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        2'b11, 5'd9,  5'd9,  32'h0000BBBB, 32'h0000BBBB, 32'h0000BBBB, 32'h0000BBBB, 1'b0};
    tbl[8]  = '{1'b1,5'd3,32'h11,       1'b0,5'd0,32'h0,        2'b10, 5'd0,  5'd3,  32'h0000BBBB, 32'h0,        32'h0000BBBB, 32'h11,       1'b0};
    tbl[9]  = '{1'b1,5'd3,32'h22,       1'b0,5'd0,32'h0,        2'b11, 5'd3,  5'd3,  32'h11,       32'h11,       32'h22,       32'h22,       1'b0};
    tbl[10] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        2'b11, 5'd3,  5'd9,  32'h22,       32'h0000BBBB, 32'h22,       32'h0000BBBB, 1'b0};
    tbl[11] = '{1'b1,5'd4,32'h44,       1'b1,5'd5,32'h55,       2'b11, 5'd4,  5'd5,  32'h0,        32'h0,        32'h44,       32'h55,       1'b0};
    tbl[12] = '{1'b1,5'd6,32'h66,       1'b1,5'd4,32'h77,       2'b11, 5'd6,  5'd4,  32'h0,        32'h44,       32'h66,       32'h77,       1'b0};
    tbl[13] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        2'b11, 5'd4,  5'd6,  32'h77,       32'h66,       32'h77,       32'h66,       1'b0};
    tbl[14] = '{1'b0,5'd4,32'h99,       1'b1,5'd4,32'h88,       2'b00, 5'd0,  5'd0,  32'h77,       32'h66,       32'h77,       32'h66,       1'b0};

    // reset state
    #12 rst_n = 1'b1;
    #1;
    chk("reset_rd_a", rd_a, 64'h0);
    chk("reset_conf_a", {63'h0, conf_a}, 64'h0);
    chk("reset_rd_c", rd_c, 64'h0);

    // asynchronous clear between edges drops an in-flight read result
    tick();
    we0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    tick();
    we0 = 0; rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
    tick();
    chk("pre_reset_read", rd_a, {2{32'hDEADBEEF}});
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_clr_rd_a", rd_a, 64'h0);
    chk("async_clr_rd_b", rd_b, 64'h0);
    chk("async_clr_conf", {62'h0, conf_a, conf_b}, 64'h0);
    #2 rst_n = 1'b1;
    rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
    tick();
    chk("post_reset_r5", rd_a, 64'h0);
    idle();

    // table: expectation queued at drive time, popped once the edge has produced it
    for (int i = 0; i < 15; i++) begin
      v = tbl[i];
      drive(v);
      sb.push_back('{v.a0, v.a1, v.b0, v.b1, v.conf, i});
      tick();
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 64'h1, 64'h0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("row%0d_a", e.row), rd_a, {e.a1, e.a0});
        chk($sformatf("row%0d_b", e.row), rd_b, {e.b1, e.b0});
        chk($sformatf("row%0d_conf", e.row), {62'h0, conf_a, conf_b}, {62'h0, e.conf, e.conf});
      end
    end
    idle();
    tick();
    chk("conf_one_cycle", {62'h0, conf_a, conf_b}, 64'h0);

    // parameter sweep: 16-bit, 8 entries, 4 lanes, r0 ordinary
    c_we0 = 1; c_wa0 = 3'd0; c_wd0 = 16'hBEEF;
    c_we1 = 1; c_wa1 = 3'd7; c_wd1 = 16'h7777;
    tick();
    c_we0 = 0; c_we1 = 0;
    c_en = 4'b1111; c_addr = {3'd7, 3'd0, 3'd7, 3'd0};
    tick();
    chk("sweep_lanes", rd_c, {16'h7777, 16'hBEEF, 16'h7777, 16'hBEEF});
    chk("sweep_conf0", {63'h0, conf_c}, 64'h0);
    c_en = '0;
    c_we0 = 1; c_wa0 = 3'd0; c_wd0 = 16'h1111;
    c_we1 = 1; c_wa1 = 3'd0; c_wd1 = 16'h2222;
    tick();
    chk("sweep_conf_r0", {63'h0, conf_c}, 64'h1);
    chk("sweep_hold", rd_c, {16'h7777, 16'hBEEF, 16'h7777, 16'hBEEF});
    c_we0 = 0; c_we1 = 0;
    c_en = 4'b1111; c_addr = '0;
    tick();
    chk("sweep_r0_port1", rd_c, {4{16'h2222}});
    chk("sweep_conf_clr", {63'h0, conf_c}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
